// File: rtl/i2c_master_defines.sv
// Shared encodings for the I2C master transaction sequencer: FSM states,
// issue phases, response error codes, address R/W bits and the command bundle.
package i2c_master_defines;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_W   = 3'd1,
        ST_REG      = 3'd2,
        ST_ADDR_R   = 3'd3,
        ST_WDATA    = 3'd4,
        ST_RDATA    = 3'd5,
        ST_ERR_STOP = 3'd6,
        ST_RESP     = 3'd7
    } seq_state_e;

    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_GAP   = 1'b1
    } issue_phase_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_ARB     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } resp_err_e;

    localparam logic ADDR_BIT_W = 1'b0;
    localparam logic ADDR_BIT_R = 1'b1;

    typedef struct packed {
        logic start;
        logic stop;
        logic read;
        logic write;
        logic tx_ack;
    } byte_cmd_t;

    localparam byte_cmd_t CMD_NONE = '0;

endpackage

// File: rtl/i2c_seq_byte_issue.sv
// Issue/gap phase tracker for one byte command: holds the command lines until
// done, forces a one-cycle idle gap, and (with I2C_SEQ_TIMEOUT_EN) runs a watchdog.
module i2c_seq_byte_issue
    import i2c_master_defines::*;
`ifdef I2C_SEQ_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 65535
)
`endif
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      active_i,
    input  byte_cmd_t cmd_i,
    input  logic      skip_gap_i,
    input  logic      done_i,
    input  logic      al_i,
    output byte_cmd_t cmd_o,
    output logic      gap_o,
    output logic      done_o,
    output logic      al_o,
    output logic      timeout_o
);

    issue_phase_e phase_q, phase_d;
    logic         issuing;

    assign issuing = active_i && (phase_q == PH_ISSUE);
    assign cmd_o   = issuing ? cmd_i : CMD_NONE;
    assign gap_o   = (phase_q == PH_GAP);
    assign al_o    = active_i && al_i;
    // Arbitration loss wins over a done reported in the same cycle.
    assign done_o  = issuing && done_i && !al_i;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wdog_q, wdog_d;
    logic        waiting;

    assign waiting   = issuing && !done_i && !al_i;
    assign timeout_o = waiting && (wdog_q == WDOG_LAST);

    always_comb begin
        wdog_d = '0;
        if (waiting) wdog_d = wdog_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        phase_d = PH_ISSUE;
        if (al_o)
            phase_d = PH_GAP;
        else if ((done_o || timeout_o) && !skip_gap_i)
            phase_d = PH_GAP;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= PH_ISSUE;
        else        phase_q <= phase_d;
    end

endmodule

// File: rtl/i2c_master_txn_seq.sv
// Register-level I2C transaction sequencer driving the byte controller's command
// lines. Optional per-byte watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_master_txn_seq
    import i2c_master_defines::*;
#(
    parameter int LEN_W = 4
`ifdef I2C_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 65535
`endif
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req_valid,
    output logic             Req_ready,
    input  logic             Req_rd,
    input  logic [6:0]       Req_dev,
    input  logic [7:0]       Req_reg,
    input  logic [LEN_W-1:0] Req_len,
    input  logic [7:0]       Wr_data,
    output logic             Wr_pop,
    output logic [7:0]       Rd_data,
    output logic             Rd_valid,
    output logic             Resp_valid,
    output logic [1:0]       Resp_err,
    output logic             Busy,
    output logic             Start,
    output logic             Stop,
    output logic             Read,
    output logic             Write,
    output logic             Tx_ack,
    output logic [7:0]       Txr,
    input  logic [7:0]       Rxr,
    input  logic             I2C_done,
    input  logic             Rx_ack,
    input  logic             I2C_al
);

    seq_state_e       state_q, state_d;
    resp_err_e        err_q, err_d;
    logic             rd_q, rd_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       txr_q, txr_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    byte_cmd_t cmd, cmd_out;
    logic      active, skip_gap, in_gap, done_evt, al_evt, to_evt, last;

    assign active = (state_q != ST_IDLE) && (state_q != ST_RESP);
    assign last   = (cnt_q == LEN_W'(1));

    i2c_seq_byte_issue
`ifdef I2C_SEQ_TIMEOUT_EN
    #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
    u_issue (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .active_i   (active),
        .cmd_i      (cmd),
        .skip_gap_i (skip_gap),
        .done_i     (I2C_done),
        .al_i       (I2C_al),
        .cmd_o      (cmd_out),
        .gap_o      (in_gap),
        .done_o     (done_evt),
        .al_o       (al_evt),
        .timeout_o  (to_evt)
    );

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        rd_d       = rd_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        txr_d      = txr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        cmd        = CMD_NONE;
        skip_gap   = 1'b0;
        Wr_pop     = 1'b0;
        Resp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Req_valid) begin
                    rd_d    = Req_rd;
                    dev_d   = Req_dev;
                    reg_d   = Req_reg;
                    cnt_d   = Req_len;
                    txr_d   = {Req_dev, ADDR_BIT_W};
                    err_d   = ERR_OK;
                    state_d = ST_ADDR_W;
                end
            end
            ST_ADDR_W: begin
                cmd.start = 1'b1;
                cmd.write = 1'b1;
                if (done_evt) state_d = ST_REG;
            end
            ST_REG: begin
                cmd.write = 1'b1;
                cmd.stop  = (cnt_q == '0);
                if (in_gap) txr_d = reg_q;
                if (done_evt) begin
                    if (cnt_q == '0) begin
                        state_d  = ST_RESP;
                        skip_gap = 1'b1;
                    end else begin
                        state_d = rd_q ? ST_ADDR_R : ST_WDATA;
                    end
                end
            end
            ST_ADDR_R: begin
                cmd.start = 1'b1;
                cmd.write = 1'b1;
                if (in_gap) txr_d = {dev_q, ADDR_BIT_R};
                if (done_evt) state_d = ST_RDATA;
            end
            ST_WDATA: begin
                cmd.write = 1'b1;
                cmd.stop  = last;
                if (in_gap) begin
                    Wr_pop = 1'b1;
                    txr_d  = Wr_data;
                end
                if (done_evt) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (last) begin
                        state_d  = ST_RESP;
                        skip_gap = 1'b1;
                    end
                end
            end
            ST_RDATA: begin
                cmd.read   = 1'b1;
                cmd.stop   = last;
                cmd.tx_ack = last;
                if (done_evt) begin
                    cnt_d      = cnt_q - LEN_W'(1);
                    rd_valid_d = 1'b1;
                    rd_data_d  = Rxr;
                    if (last) begin
                        state_d  = ST_RESP;
                        skip_gap = 1'b1;
                    end
                end
            end
            ST_ERR_STOP: begin
                cmd.stop = 1'b1;
                if (done_evt) begin
                    state_d  = ST_RESP;
                    skip_gap = 1'b1;
                end
            end
            ST_RESP: begin
                // A gap here is the command-drop cycle after arbitration loss.
                if (!in_gap) begin
                    Resp_valid = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A NACKed write byte that already carried Stop needs no extra Stop.
        if (done_evt && cmd.write && Rx_ack) begin
            err_d    = ERR_NACK;
            state_d  = cmd.stop ? ST_RESP : ST_ERR_STOP;
            skip_gap = cmd.stop;
        end

        if (to_evt) begin
            err_d    = ERR_TIMEOUT;
            state_d  = ST_RESP;
            skip_gap = 1'b1;
        end

        if (al_evt) begin
            err_d      = ERR_ARB;
            state_d    = ST_RESP;
            skip_gap   = 1'b0;
            Wr_pop     = 1'b0;
            txr_d      = txr_q;
            cnt_d      = cnt_q;
            rd_valid_d = 1'b0;
            rd_data_d  = rd_data_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_OK;
            rd_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            cnt_q      <= '0;
            txr_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            cnt_q      <= cnt_d;
            txr_q      <= txr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign Req_ready = (state_q == ST_IDLE);
    assign Busy      = (state_q != ST_IDLE);
    assign Resp_err  = Resp_valid ? err_q : ERR_OK;
    assign Txr       = txr_q;
    assign Rd_data   = rd_data_q;
    assign Rd_valid  = rd_valid_q;
    assign Start     = cmd_out.start;
    assign Stop      = cmd_out.stop;
    assign Read      = cmd_out.read;
    assign Write     = cmd_out.write;
    assign Tx_ack    = cmd_out.tx_ack;

endmodule

// File: tb/tb_i2c_master_txn_seq.sv
// Directed self-checking bench for i2c_master_txn_seq with a scripted byte
// controller; the timeout scenario runs only when I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_master_txn_seq;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Req_valid = 1'b0;
    logic       Req_ready;
    logic       Req_rd = 1'b0;
    logic [6:0] Req_dev = '0;
    logic [7:0] Req_reg = '0;
    logic [3:0] Req_len = '0;
    logic [7:0] Wr_data;
    logic       Wr_pop;
    logic [7:0] Rd_data;
    logic       Rd_valid;
    logic       Resp_valid;
    logic [1:0] Resp_err;
    logic       Busy;
    logic       Start, Stop, Read, Write, Tx_ack;
    logic [7:0] Txr;
    logic [7:0] Rxr = '0;
    logic       I2C_done = 1'b0;
    logic       Rx_ack = 1'b0;
    logic       I2C_al = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wr_mem [4];
    int         wr_idx = 0;
    int         pop_cnt = 0;
    logic [7:0] rd_log [$];

    always #5 Clk = ~Clk;

    i2c_master_txn_seq #(
        .LEN_W(4)
`ifdef I2C_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC(100)
`endif
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_rd(Req_rd),
        .Req_dev(Req_dev), .Req_reg(Req_reg), .Req_len(Req_len),
        .Wr_data(Wr_data), .Wr_pop(Wr_pop),
        .Rd_data(Rd_data), .Rd_valid(Rd_valid),
        .Resp_valid(Resp_valid), .Resp_err(Resp_err), .Busy(Busy),
        .Start(Start), .Stop(Stop), .Read(Read), .Write(Write), .Tx_ack(Tx_ack),
        .Txr(Txr), .Rxr(Rxr), .I2C_done(I2C_done), .Rx_ack(Rx_ack), .I2C_al(I2C_al)
    );

    // Show-ahead write FIFO model.
    assign Wr_data = wr_mem[wr_idx % 4];
    always @(posedge Clk) if (Wr_pop) wr_idx <= wr_idx + 1;

    always @(negedge Clk) begin
        if (Wr_pop) pop_cnt++;
        if (Rd_valid) rd_log.push_back(Rd_data);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [4:0] cmd_now();
        return {Start, Stop, Read, Write, Tx_ack};
    endfunction

    task automatic issue_req(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [3:0] len);
        Req_rd = rd; Req_dev = dev; Req_reg = rg; Req_len = len; Req_valid = 1'b1;
        tick();
        Req_valid = 1'b0;
    endtask

    task automatic wait_cmd(input string tag, output logic [4:0] c);
        int n = 0;
        while (cmd_now() == 5'b0 && n < 50) begin
            tick();
            n++;
        end
        if (cmd_now() == 5'b0) check({tag, "_wait"}, 32'd0, 32'd1);
        c = cmd_now();
    endtask

    // Waits for the next command, checks it, then returns done after two cycles.
    task automatic run_byte(input string tag, input logic [4:0] exp_cmd, input bit chk_txr,
                            input logic [7:0] exp_txr, input logic nack, input logic [7:0] rx,
                            input logic al, input bit chk_gap);
        logic [4:0] c;
        wait_cmd(tag, c);
        check({tag, "_cmd"}, 32'(c), 32'(exp_cmd));
        if (chk_txr) check({tag, "_txr"}, 32'(Txr), 32'(exp_txr));
        tick();
        tick();
        I2C_done = 1'b1; Rx_ack = nack; Rxr = rx; I2C_al = al;
        tick();
        I2C_done = 1'b0; Rx_ack = 1'b0; I2C_al = 1'b0;
        if (chk_gap) check({tag, "_gap"}, 32'(cmd_now()), 32'd0);
    endtask

    localparam logic [4:0] C_ADDR = 5'b10010;
    localparam logic [4:0] C_WR   = 5'b00010;
    localparam logic [4:0] C_WRS  = 5'b01010;
    localparam logic [4:0] C_RD   = 5'b00100;
    localparam logic [4:0] C_RDL  = 5'b01101;
    localparam logic [4:0] C_STOP = 5'b01000;

    initial begin
        wr_mem[0] = 8'hA5; wr_mem[1] = 8'h3C; wr_mem[2] = 8'h00; wr_mem[3] = 8'h00;
        #12;
        check("rst_ready", 32'(Req_ready), 32'd1);
        check("rst_ctl", 32'({Busy, Start, Stop, Read, Write, Tx_ack, Wr_pop, Rd_valid, Resp_valid}), 32'd0);
        check("rst_data", 32'({Txr, Rd_data, Resp_err}), 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        tick();

        // Write dev 0x50 reg 0x10, two bytes.
        issue_req(1'b0, 7'h50, 8'h10, 4'd2);
        check("w_lat", 32'({Start, Write, Txr}), 32'({2'b11, 8'hA0}));
        check("w_busy", 32'({Busy, Req_ready}), 32'b10);
        run_byte("w_addr", C_ADDR, 1, 8'hA0, 0, 8'h00, 0, 1);
        run_byte("w_reg",  C_WR,   1, 8'h10, 0, 8'h00, 0, 1);
        run_byte("w_d0",   C_WR,   1, 8'hA5, 0, 8'h00, 0, 1);
        run_byte("w_d1",   C_WRS,  1, 8'h3C, 0, 8'h00, 0, 0);
        check("w_resp", 32'({Resp_valid, Resp_err}), 32'b100);
        check("w_pops", 32'(pop_cnt), 32'd2);
        tick();
        check("w_idle", 32'({Busy, Req_ready, Resp_valid}), 32'b010);

        // Read dev 0x50 reg 0x02, three bytes; Req_dev change after accept is ignored.
        issue_req(1'b1, 7'h50, 8'h02, 4'd3);
        Req_dev = 7'h7F;
        run_byte("r_addr",  C_ADDR, 1, 8'hA0, 0, 8'h00, 0, 1);
        run_byte("r_reg",   C_WR,   1, 8'h02, 0, 8'h00, 0, 1);
        run_byte("r_addr2", C_ADDR, 1, 8'hA1, 0, 8'h00, 0, 1);
        run_byte("r_d0",    C_RD,   0, 8'h00, 0, 8'h11, 0, 1);
        run_byte("r_d1",    C_RD,   0, 8'h00, 0, 8'h22, 0, 1);
        run_byte("r_d2",    C_RDL,  0, 8'h00, 0, 8'h33, 0, 0);
        check("r_resp", 32'({Resp_valid, Resp_err}), 32'b100);
        tick();
        check("r_nrd", 32'(rd_log.size()), 32'd3);
        if (rd_log.size() == 3) begin
            check("r_rd0", 32'(rd_log[0]), 32'h11);
            check("r_rd1", 32'(rd_log[1]), 32'h22);
            check("r_rd2", 32'(rd_log[2]), 32'h33);
        end
        rd_log.delete();

        // Write NACKed on the address byte.
        issue_req(1'b0, 7'h50, 8'h10, 4'd1);
        run_byte("n_addr", C_ADDR, 1, 8'hA0, 1, 8'h00, 0, 1);
        run_byte("n_stop", C_STOP, 0, 8'h00, 0, 8'h00, 0, 0);
        check("n_resp", 32'({Resp_valid, Resp_err}), 32'b101);
        check("n_pops", 32'(pop_cnt), 32'd2);
        tick();

        // Arbitration lost together with done on the second read byte.
        issue_req(1'b1, 7'h50, 8'h02, 4'd3);
        run_byte("a_addr",  C_ADDR, 1, 8'hA0, 0, 8'h00, 0, 1);
        run_byte("a_reg",   C_WR,   1, 8'h02, 0, 8'h00, 0, 1);
        run_byte("a_addr2", C_ADDR, 1, 8'hA1, 0, 8'h00, 0, 1);
        run_byte("a_d0",    C_RD,   0, 8'h00, 0, 8'h11, 0, 1);
        run_byte("a_d1",    C_RD,   0, 8'h00, 0, 8'h22, 1, 0);
        check("a_drop", 32'({cmd_now(), Resp_valid}), 32'd0);
        tick();
        check("a_resp", 32'({Resp_valid, Resp_err, Stop}), 32'b1100);
        tick();
        check("a_nrd", 32'(rd_log.size()), 32'd1);
        rd_log.delete();

        // Read with zero length: register byte carries Stop, no repeated start.
        issue_req(1'b1, 7'h50, 8'h07, 4'd0);
        run_byte("z_addr", C_ADDR, 1, 8'hA0, 0, 8'h00, 0, 1);
        run_byte("z_reg",  C_WRS,  1, 8'h07, 0, 8'h00, 0, 0);
        check("z_resp", 32'({Resp_valid, Resp_err}), 32'b100);
        tick();
        check("z_nrd", 32'(rd_log.size()), 32'd0);

        // Reset while the register byte is being issued.
        issue_req(1'b0, 7'h50, 8'h09, 4'd0);
        run_byte("x_addr", C_ADDR, 1, 8'hA0, 0, 8'h00, 0, 1);
        begin
            logic [4:0] c;
            wait_cmd("x_reg", c);
            check("x_reg_cmd", 32'(c), 32'(C_WRS));
        end
        Rst_n = 1'b0;
        #1;
        check("x_ready", 32'(Req_ready), 32'd1);
        check("x_ctl", 32'({Busy, Start, Stop, Read, Write, Tx_ack, Wr_pop, Rd_valid, Resp_valid}), 32'd0);
        check("x_data", 32'({Txr, Rd_data, Resp_err}), 32'd0);
        tick();
        Rst_n = 1'b1;
        tick();

`ifdef I2C_SEQ_TIMEOUT_EN
        begin
            int held = 0;
            issue_req(1'b0, 7'h50, 8'h10, 4'd1);
            while (Start && held < 200) begin
                tick();
                held++;
            end
            check("t_held", 32'(held), 32'd100);
            check("t_resp", 32'({Resp_valid, Resp_err}), 32'b111);
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
